// File: rtl/fpu_io_sequencer.sv
// Front-end sequencer for the FPU board: assembles operands from switch chunks on key
// presses, hands them to a start/done arithmetic core and shows the result on the LEDs.
module fpu_io_sequencer #(
  parameter int DATA_W      = 32,
  parameter int SW_W        = 16,
  parameter int OP_W        = 2,
  parameter int LED_RED_W   = 18,
  parameter int LED_YEL_W   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   key3,
  input  logic                   key0,
  input  logic                   key1,
  input  logic                   key2,
  input  logic [SW_W+OP_W-1:0]   i_switch,
  output logic [DATA_W-1:0]      o_operand_a,
  output logic [DATA_W-1:0]      o_operand_b,
  output logic [OP_W-1:0]        o_op_sel,
  output logic                   o_start,
  input  logic                   i_done,
  input  logic [DATA_W-1:0]      i_result,
  input  logic                   i_zero_div,
  output logic                   o_busy,
  output logic [LED_RED_W-1:0]   o_LED_red,
  output logic [LED_YEL_W-1:0]   o_LED_yellow,
  output logic                   o_LED_zero,
  output logic                   o_LED_err
);

  localparam int NCHUNK = DATA_W / SW_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [OP_W-1:0]  OP_DIV     = OP_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_SHOW
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2:0]        w_keys;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_prev;
  logic [2:0]        w_press;

  logic [SW_W-1:0]   w_chunk;
  logic [OP_W-1:0]   w_op;

  logic              w_accept;
  logic              w_load_a;
  logic              w_load_b;
  logic              w_exec;
  logic              w_last_a;
  logic              w_last_b;
  logic              w_timeout;

  logic [CNT_W-1:0]  r_cnt_a;
  logic [CNT_W-1:0]  r_cnt_b;
  logic [DATA_W-1:0] r_shadow_a;
  logic [DATA_W-1:0] r_shadow_b;
  logic [DATA_W-1:0] w_shadow_a;
  logic [DATA_W-1:0] w_shadow_b;
  logic [DATA_W-1:0] r_operand_a;
  logic [DATA_W-1:0] r_operand_b;
  logic [OP_W-1:0]   r_op_sel;
  logic [TMR_W-1:0]  r_timer;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_err;

  assign w_keys  = {key2, key1, key0};
  assign w_chunk = i_switch[SW_W-1:0];
  assign w_op    = i_switch[SW_W+OP_W-1:SW_W];

  // Keys idle high, so the synchroniser resets to 1 to avoid a fake press after reset.
  always_ff @(posedge clk or negedge key3) begin
    if (!key3) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press = r_prev & ~r_sync2;

  assign w_accept  = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_SHOW);
  assign w_load_a  = w_accept & w_press[0];
  assign w_load_b  = w_accept & w_press[1] & ~w_press[0];
  assign w_exec    = w_accept & w_press[2] & ~w_press[1] & ~w_press[0];
  assign w_last_a  = (r_cnt_a == LAST_CHUNK);
  assign w_last_b  = (r_cnt_b == LAST_CHUNK);
  assign w_timeout = (r_state == S_WAIT) & ~i_done & (r_timer == TMR_LAST);

  always_ff @(posedge clk or negedge key3) begin
    if (!key3) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_start      = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD, S_SHOW: begin
        if (w_exec) begin
          w_next_state = S_START;
        end else if (w_load_a) begin
          w_next_state = w_last_a ? S_IDLE : S_LOAD;
        end else if (w_load_b) begin
          w_next_state = w_last_b ? S_IDLE : S_LOAD;
        end
      end
      S_START: begin
        o_start      = 1'b1;
        o_busy       = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (i_done || w_timeout) begin
          w_next_state = S_SHOW;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Chunk 0 is the most significant slice; the completed word is visible the same edge.
  always_comb begin
    w_shadow_a = r_shadow_a;
    w_shadow_b = r_shadow_b;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_cnt_a == CNT_W'(k)) begin
        w_shadow_a[DATA_W-1-k*SW_W -: SW_W] = w_chunk;
      end
      if (r_cnt_b == CNT_W'(k)) begin
        w_shadow_b[DATA_W-1-k*SW_W -: SW_W] = w_chunk;
      end
    end
  end

  always_ff @(posedge clk or negedge key3) begin
    if (!key3) begin
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_shadow_a  <= '0;
      r_shadow_b  <= '0;
      r_operand_a <= '0;
      r_operand_b <= '0;
    end else if (r_state == S_START) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_load_a) begin
      r_shadow_a <= w_shadow_a;
      r_cnt_b    <= '0;
      if (w_last_a) begin
        r_operand_a <= w_shadow_a;
        r_cnt_a     <= '0;
      end else begin
        r_cnt_a <= r_cnt_a + CNT_W'(1);
      end
    end else if (w_load_b) begin
      r_shadow_b <= w_shadow_b;
      r_cnt_a    <= '0;
      if (w_last_b) begin
        r_operand_b <= w_shadow_b;
        r_cnt_b     <= '0;
      end else begin
        r_cnt_b <= r_cnt_b + CNT_W'(1);
      end
    end
  end

  // A timeout keeps the previous result and zero flag; only the error lamp changes.
  always_ff @(posedge clk or negedge key3) begin
    if (!key3) begin
      r_op_sel <= '0;
      r_timer  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_START: begin
          r_op_sel <= w_op;
          r_timer  <= '0;
          r_err    <= 1'b0;
        end
        S_WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (i_done) begin
            if ((r_op_sel == OP_DIV) && i_zero_div) begin
              r_result <= '0;
              r_zero   <= 1'b1;
            end else begin
              r_result <= i_result;
              r_zero   <= 1'b0;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_operand_a  = r_operand_a;
  assign o_operand_b  = r_operand_b;
  assign o_op_sel     = r_op_sel;
  assign o_LED_red    = r_result[DATA_W-1 -: LED_RED_W];
  assign o_LED_yellow = r_result[DATA_W-1-LED_RED_W -: LED_YEL_W];
  assign o_LED_zero   = r_zero;
  assign o_LED_err    = r_err;

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Self-checking bench for fpu_io_sequencer: directed and randomised key/core activity
// compared against a queue-based behavioural model of operand loading and result capture.
module tb_fpu_io_sequencer;

  localparam int DATA_W      = 32;
  localparam int SW_W        = 16;
  localparam int OP_W        = 2;
  localparam int LED_RED_W   = 18;
  localparam int LED_YEL_W   = 8;
  localparam int TIMEOUT_CYC = 1024;
  localparam int NCHUNK      = DATA_W / SW_W;

  logic                 clk = 1'b0;
  logic                 key3, key0, key1, key2;
  logic [SW_W+OP_W-1:0] i_switch;
  logic [DATA_W-1:0]    o_operand_a, o_operand_b;
  logic [OP_W-1:0]      o_op_sel;
  logic                 o_start, i_done, i_zero_div, o_busy;
  logic [DATA_W-1:0]    i_result;
  logic [LED_RED_W-1:0] o_LED_red;
  logic [LED_YEL_W-1:0] o_LED_yellow;
  logic                 o_LED_zero, o_LED_err;

  fpu_io_sequencer #(
    .DATA_W(DATA_W), .SW_W(SW_W), .OP_W(OP_W),
    .LED_RED_W(LED_RED_W), .LED_YEL_W(LED_YEL_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .key3(key3), .key0(key0), .key1(key1), .key2(key2),
    .i_switch(i_switch), .o_operand_a(o_operand_a), .o_operand_b(o_operand_b),
    .o_op_sel(o_op_sel), .o_start(o_start), .i_done(i_done), .i_result(i_result),
    .i_zero_div(i_zero_div), .o_busy(o_busy), .o_LED_red(o_LED_red),
    .o_LED_yellow(o_LED_yellow), .o_LED_zero(o_LED_zero), .o_LED_err(o_LED_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int startCount  = 0;

  always @(posedge clk) if (o_start === 1'b1) startCount++;

  logic [DATA_W-1:0] mA, mB, mRes;
  logic              mZero, mErr;
  logic [OP_W-1:0]   mOp;
  logic [SW_W-1:0]   qA[$];
  logic [SW_W-1:0]   qB[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mA = '0; mB = '0; mRes = '0; mZero = 1'b0; mErr = 1'b0; mOp = '0;
    qA.delete(); qB.delete();
  endtask

  function automatic logic [DATA_W-1:0] assemble(input logic [SW_W-1:0] q[$]);
    logic [DATA_W-1:0] v = '0;
    foreach (q[i]) v = (v << SW_W) | DATA_W'(q[i]);
    return v;
  endfunction

  task automatic modelLoad(input bit isB, input logic [SW_W-1:0] chunk);
    if (!isB) begin
      qB.delete();
      qA.push_back(chunk);
      if (qA.size() == NCHUNK) begin mA = assemble(qA); qA.delete(); end
    end else begin
      qA.delete();
      qB.push_back(chunk);
      if (qB.size() == NCHUNK) begin mB = assemble(qB); qB.delete(); end
    end
  endtask

  task automatic checkLeds(input string tag);
    checkOutput({tag, "_red"}, 64'(o_LED_red), 64'(mRes >> (DATA_W - LED_RED_W)));
    checkOutput({tag, "_yel"}, 64'(o_LED_yellow),
                64'((mRes >> (DATA_W - LED_RED_W - LED_YEL_W)) & ((1 << LED_YEL_W) - 1)));
    checkOutput({tag, "_zero"}, 64'(o_LED_zero), 64'(mZero));
    checkOutput({tag, "_err"}, 64'(o_LED_err), 64'(mErr));
  endtask

  // Press the keys in mask (bit0=key0, bit1=key1, bit2=key2) for 'hold' cycles.
  task automatic applyStimulus(input logic [2:0] mask, input logic [SW_W-1:0] chunk,
                               input logic [OP_W-1:0] op, input int hold);
    i_switch = {op, chunk};
    if (mask[0]) key0 = 1'b0;
    if (mask[1]) key1 = 1'b0;
    if (mask[2]) key2 = 1'b0;
    tick(hold);
    key0 = 1'b1; key1 = 1'b1; key2 = 1'b1;
    tick(4);
    if (mask[0]) modelLoad(1'b0, chunk);
    else if (mask[1]) modelLoad(1'b1, chunk);
    checkOutput("operand_a", 64'(o_operand_a), 64'(mA));
    checkOutput("operand_b", 64'(o_operand_b), 64'(mB));
  endtask

  task automatic loadWord(input bit isB, input logic [DATA_W-1:0] w);
    for (int k = 0; k < NCHUNK; k++)
      applyStimulus(isB ? 3'b010 : 3'b001, SW_W'(w >> (DATA_W - (k + 1) * SW_W)),
                    OP_W'($urandom), $urandom_range(1, 4));
  endtask

  // Press key2, follow the start pulse and optionally answer as the core.
  task automatic runOp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] res,
                       input logic zd, input int lat, input bit giveDone);
    int waited = 0;
    i_switch = {op, SW_W'($urandom)};
    key2 = 1'b0;
    while (o_start !== 1'b1 && waited < 12) begin tick(1); waited++; end
    checkOutput("start_seen", 64'(o_start), 64'(1));
    if (o_start !== 1'b1) begin key2 = 1'b1; tick(4); return; end
    checkOutput("busy_start", 64'(o_busy), 64'(1));
    qA.delete(); qB.delete();
    mOp = op; mErr = 1'b0;
    tick(1);
    key2 = 1'b1;
    checkOutput("start_one_cycle", 64'(o_start), 64'(0));
    checkOutput("busy_wait", 64'(o_busy), 64'(1));
    checkOutput("op_sel", 64'(o_op_sel), 64'(mOp));
    checkOutput("err_cleared", 64'(o_LED_err), 64'(0));
    checkOutput("core_a", 64'(o_operand_a), 64'(mA));
    checkOutput("core_b", 64'(o_operand_b), 64'(mB));
    if (!giveDone) return;
    tick(lat);
    i_done = 1'b1; i_result = res; i_zero_div = zd;
    tick(1);
    i_done = 1'b0; i_zero_div = 1'b0; i_result = DATA_W'($urandom);
    if (op == OP_W'(3) && zd) begin mRes = '0; mZero = 1'b1; end
    else begin mRes = res; mZero = 1'b0; end
    checkOutput("busy_done", 64'(o_busy), 64'(0));
    checkLeds("done");
  endtask

  task automatic doReset();
    key0 = 1'b1; key1 = 1'b1; key2 = 1'b1; i_done = 1'b0;
    tick(1);
    #2 key3 = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_a", 64'(o_operand_a), 64'(0));
    checkOutput("rst_b", 64'(o_operand_b), 64'(0));
    checkOutput("rst_op", 64'(o_op_sel), 64'(0));
    checkOutput("rst_start", 64'(o_start), 64'(0));
    checkOutput("rst_busy", 64'(o_busy), 64'(0));
    checkLeds("rst");
    tick(2);
    key3 = 1'b1;
    tick(2);
  endtask

  initial begin
    int sc;
    logic [DATA_W-1:0] saved;
    logic [SW_W-1:0] c;
    key3 = 1'b0; key0 = 1'b1; key1 = 1'b1; key2 = 1'b1;
    i_switch = '0; i_done = 1'b0; i_result = '0; i_zero_div = 1'b0;
    modelReset();
    tick(2);
    checkOutput("por_a", 64'(o_operand_a), 64'(0));
    checkOutput("por_busy", 64'(o_busy), 64'(0));
    checkLeds("por");
    key3 = 1'b1;
    tick(2);

    $display("[TB] known vector 1.0 + 2.0");
    loadWord(1'b0, 32'h3F80_0000);
    loadWord(1'b1, 32'h4000_0000);
    sc = startCount;
    runOp(2'b00, 32'h4040_0000, 1'b0, 3, 1'b1);
    checkOutput("known_red", 64'(o_LED_red), 64'h10100);
    checkOutput("known_yel", 64'(o_LED_yellow), 64'h00);
    checkOutput("known_starts", 64'(startCount - sc), 64'(1));

    $display("[TB] divide by zero");
    loadWord(1'b1, 32'h0);
    runOp(2'b11, 32'hDEAD_BEEF, 1'b1, 5, 1'b1);
    checkOutput("dz_zero", 64'(o_LED_zero), 64'(1));
    checkOutput("dz_red", 64'(o_LED_red), 64'(0));
    runOp(2'b00, 32'h1234_5678, 1'b0, 2, 1'b1);
    checkOutput("dz_cleared", 64'(o_LED_zero), 64'(0));

    $display("[TB] done outside WAIT ignored");
    i_done = 1'b1; i_result = 32'hFFFF_FFFF; i_zero_div = 1'b1;
    tick(3);
    i_done = 1'b0; i_zero_div = 1'b0;
    checkLeds("stray_done");

    $display("[TB] long key0 hold");
    saved = mA;
    applyStimulus(3'b001, 16'hA5A5, 2'b00, 100);
    checkOutput("hold_a_unchanged", 64'(o_operand_a), 64'(saved));
    applyStimulus(3'b001, 16'h5A5A, 2'b00, 3);
    checkOutput("hold_a_complete", 64'(o_operand_a), 64'hA5A5_5A5A);

    $display("[TB] partial A discarded by B loads");
    saved = mA;
    applyStimulus(3'b001, 16'h1111, 2'b00, 2);
    applyStimulus(3'b010, 16'h2222, 2'b00, 2);
    applyStimulus(3'b010, 16'h3333, 2'b00, 2);
    checkOutput("discard_a", 64'(o_operand_a), 64'(saved));
    checkOutput("discard_b", 64'(o_operand_b), 64'h2222_3333);
    applyStimulus(3'b001, 16'h4444, 2'b00, 2);
    applyStimulus(3'b001, 16'h5555, 2'b00, 2);
    checkOutput("fresh_a", 64'(o_operand_a), 64'h4444_5555);

    $display("[TB] simultaneous presses");
    applyStimulus(3'b010, 16'h6666, 2'b00, 2);
    applyStimulus(3'b011, 16'h7777, 2'b00, 2);
    applyStimulus(3'b001, 16'h8888, 2'b00, 2);
    checkOutput("prio_a", 64'(o_operand_a), 64'h7777_8888);
    sc = startCount;
    applyStimulus(3'b101, 16'h9999, 2'b00, 2);
    checkOutput("prio_no_start", 64'(startCount - sc), 64'(0));
    checkOutput("prio_not_busy", 64'(o_busy), 64'(0));
    applyStimulus(3'b001, 16'hAAAA, 2'b00, 2);
    checkOutput("prio_a2", 64'(o_operand_a), 64'h9999_AAAA);

    $display("[TB] core timeout");
    sc = startCount;
    runOp(2'b10, '0, 1'b0, 0, 1'b0);
    for (int i = 2; i <= TIMEOUT_CYC; i++) begin
      tick(1);
      key2 = ((i % 16) < 8 && i < TIMEOUT_CYC - 40) ? 1'b0 : 1'b1;
    end
    checkOutput("to_busy_last", 64'(o_busy), 64'(1));
    checkOutput("to_err_early", 64'(o_LED_err), 64'(0));
    tick(1);
    mErr = 1'b1;
    checkOutput("to_busy_off", 64'(o_busy), 64'(0));
    checkLeds("timeout");
    checkOutput("to_starts", 64'(startCount - sc), 64'(1));
    i_done = 1'b1; i_result = 32'hCAFE_F00D;
    tick(2);
    i_done = 1'b0;
    checkLeds("to_stray");
    runOp(2'b01, 32'h0BAD_CAFE, 1'b0, 4, 1'b1);

    $display("[TB] async reset mid-load and mid-WAIT");
    applyStimulus(3'b001, 16'hBEEF, 2'b00, 2);
    doReset();
    applyStimulus(3'b001, 16'hC0DE, 2'b00, 2);
    applyStimulus(3'b001, 16'hF00D, 2'b00, 2);
    checkOutput("post_rst_a", 64'(o_operand_a), 64'hC0DE_F00D);
    runOp(2'b11, '0, 1'b0, 0, 1'b0);
    tick(3);
    doReset();

    $display("[TB] randomised sequences");
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0: loadWord(1'b0, $urandom);
        1: loadWord(1'b1, $urandom);
        2: begin
          applyStimulus(3'b001, SW_W'($urandom), OP_W'($urandom), 2);
          loadWord(1'b1, $urandom);
        end
        3: applyStimulus(3'b001, SW_W'($urandom), OP_W'($urandom), 2);
        default: tick(1);
      endcase
      c = SW_W'($urandom);
      runOp(OP_W'($urandom_range(0, 3)), {c, SW_W'($urandom)}, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
